// File: rtl/fix_point_neuron_accumulator.sv
// Sums NUM_INPUTS sign-magnitude products plus a bias in wide two's complement and
// returns a saturated sign-magnitude result. Define FXP_NEURON_RELU_EN to apply ReLU to the result.
module fix_point_neuron_accumulator #(
    parameter int N               = 16,
    parameter int FRACTIONAL_BITS = 13,
    parameter int NUM_INPUTS      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] bias,
    input  logic [N-1:0] prod,
    input  logic         prod_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         out_valid,
    output logic         overflow,
    output logic         busy
);

    localparam int ACC_W = N + 1 + $clog2(NUM_INPUTS + 1);
    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);
    localparam logic [ACC_W-1:0] MAX_MAG  = ACC_W'((2 ** (N - 1)) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [N-1:0]            bias_q, bias_d;
    logic [N-1:0]            sum_q, sum_d;
    logic                    overflow_q, overflow_d;

    logic                    load;
    logic signed [ACC_W-1:0] final_v;
    logic [ACC_W-1:0]        final_mag;
    logic [N-1:0]            sat_word;
    logic                    sat_ovf;

    // Negative zero naturally maps to 0 since -0 == 0.
    function automatic logic signed [ACC_W-1:0] to_acc(input logic [N-1:0] x);
        logic signed [ACC_W-1:0] mag;
        mag = {{(ACC_W - N + 1){1'b0}}, x[N-2:0]};
        return x[N-1] ? -mag : mag;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            bias_q     <= '0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            bias_q     <= bias_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = ACCUM;
            ACCUM: if (prod_valid && count_q == LAST_CNT) state_d = BIAS;
            BIAS:  state_d = DONE;
            DONE:  if (out_ready) state_d = start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A handshake in DONE together with start restarts without passing through IDLE.
    assign load = start && ((state_q == IDLE) || (state_q == DONE && out_ready));

    always_comb begin
        final_v   = acc_q + to_acc(bias_q);
        final_mag = final_v[ACC_W-1] ? ACC_W'(-final_v) : ACC_W'(final_v);
        if (final_mag > MAX_MAG) begin
            sat_word = {final_v[ACC_W-1], {(N - 1){1'b1}}};
            sat_ovf  = 1'b1;
        end else begin
            sat_word = {final_v[ACC_W-1], final_mag[N-2:0]};
            sat_ovf  = 1'b0;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        count_d    = count_q;
        bias_d     = bias_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        if (load) begin
            acc_d   = '0;
            count_d = '0;
            bias_d  = bias;
        end else if (state_q == ACCUM && prod_valid) begin
            acc_d   = acc_q + to_acc(prod);
            count_d = count_q + 1'b1;
        end else if (state_q == BIAS) begin
            acc_d      = final_v;
            overflow_d = sat_ovf;
`ifdef FXP_NEURON_RELU_EN
            sum_d      = sat_word[N-1] ? '0 : sat_word;
`else
            sum_d      = sat_word;
`endif
        end
    end

    always_comb begin
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = sum_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_fix_point_neuron_accumulator.sv
// Self-checking bench for fix_point_neuron_accumulator (N=16, FRACTIONAL_BITS=13, NUM_INPUTS=4).
// Expected results are queued when a run is launched and popped when out_valid appears.
module tb_fix_point_neuron_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bias;
    logic [15:0] prod;
    logic        prod_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        out_valid;
    logic        overflow;
    logic        busy;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    exp_t sbQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    fix_point_neuron_accumulator #(
        .N(16), .FRACTIONAL_BITS(13), .NUM_INPUTS(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .prod(prod),
        .prod_valid(prod_valid), .out_ready(out_ready), .sum(sum),
        .out_valid(out_valid), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int smToInt(input logic [15:0] x);
        int m;
        m = int'({17'd0, x[14:0]});
        return x[15] ? -m : m;
    endfunction

    // Reference: exact integer sum, then clamp to +/-32767 and encode sign-magnitude.
    function automatic exp_t model(input logic [15:0] b, input logic [3:0][15:0] p);
        int   v;
        exp_t r;
        v = smToInt(b);
        for (int i = 0; i < 4; i++) v += smToInt(p[i]);
        if (v > 32767)       r = '{sum: 16'h7FFF, ovf: 1'b1};
        else if (v < -32767) r = '{sum: 16'hFFFF, ovf: 1'b1};
        else if (v < 0)      r = '{sum: {1'b1, 15'(-v)}, ovf: 1'b0};
        else                 r = '{sum: {1'b0, 15'(v)}, ovf: 1'b0};
`ifdef FXP_NEURON_RELU_EN
        if (r.sum[15]) r.sum = 16'h0000;
`endif
        return r;
    endfunction

    task automatic feedProds(input logic [3:0][15:0] p, input int gap, input bit pokeStart);
        for (int i = 0; i < 4; i++) begin
            prod       = p[i];
            prod_valid = 1'b1;
            tick();
            prod_valid = 1'b0;
            prod       = 16'h0;
            if (i < 3) begin
                repeat (gap) begin
                    if (pokeStart) begin
                        start = 1'b1;
                        bias  = 16'h7FFF;
                    end
                    tick();
                    start = 1'b0;
                    bias  = 16'h0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] b, input logic [3:0][15:0] p, input int gap,
                                 input logic [15:0] expSum, input logic expOvf, input bit pokeStart);
        sbQ.push_back('{sum: expSum, ovf: expOvf});
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = 16'h0;
        feedProds(p, gap, pokeStart);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic popCompare(input string tag, output exp_t e);
        e = '{sum: 16'hxxxx, ovf: 1'bx};
        check({tag, "_sb"}, {31'd0, sbQ.size() > 0}, 32'd1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check({tag, "_sum"}, {16'd0, sum}, {16'd0, e.sum});
            check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        waitValid(tag);
        popCompare(tag, e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_hold"}, {16'd0, sum}, {16'd0, e.sum});
    endtask

    initial begin
        logic [3:0][15:0] t1;
        logic [3:0][15:0] pr;
        exp_t e;
        t1 = {16'h1000, 16'hA000, 16'h2000, 16'h2000};

        rst = 1'b1; start = 1'b0; bias = 16'h0; prod = 16'h0;
        prod_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        prod_valid = 1'b1; prod = 16'h2000;
        tick();
        prod_valid = 1'b0;
        check("idle_prod_ignored", {31'd0, busy}, 32'd0);

        $display("[TB] basic sum and latency");
        applyStimulus(16'h0000, t1, 0, 16'h3000, 1'b0, 1'b0);
        check("t1_lat_k1", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_lat_k2", {31'd0, out_valid}, 32'd1);
        checkOutput("t1");

        $display("[TB] saturation");
        applyStimulus(16'h0000, {4{16'h6000}}, 0, 16'h7FFF, 1'b1, 1'b0);
        checkOutput("t2_pos");
`ifdef FXP_NEURON_RELU_EN
        applyStimulus(16'h0000, {4{16'hE000}}, 0, 16'h0000, 1'b1, 1'b0);
`else
        applyStimulus(16'h0000, {4{16'hE000}}, 0, 16'hFFFF, 1'b1, 1'b0);
`endif
        checkOutput("t2_neg");

        $display("[TB] negative zero and gaps");
        applyStimulus(16'h8000, {4{16'h8000}}, 0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t3_negzero");
        applyStimulus(16'h0000, t1, 3, 16'h3000, 1'b0, 1'b1);
        checkOutput("t3_gaps");

        $display("[TB] backpressure and restart");
        applyStimulus(16'h9000, {16'h0000, 16'h2000, 16'h2000, 16'h2000}, 0, 16'h5000, 1'b0, 1'b0);
        waitValid("t4");
        popCompare("t4", e);
        for (int i = 0; i < 5; i++) begin
            prod_valid = 1'b1; prod = 16'h2000;
            start = (i % 2 == 0); bias = 16'h1000;
            tick();
            check("t4_stall_valid", {31'd0, out_valid}, 32'd1);
            check("t4_stall_sum", {16'd0, sum}, {16'd0, e.sum});
        end
        prod_valid = 1'b0; start = 1'b0;
        sbQ.push_back('{sum: 16'h3000, ovf: 1'b0});
        out_ready = 1'b1; start = 1'b1; bias = 16'h0000;
        tick();
        out_ready = 1'b0; start = 1'b0;
        check("t4_restart_valid", {31'd0, out_valid}, 32'd0);
        check("t4_restart_busy", {31'd0, busy}, 32'd1);
        feedProds(t1, 0, 1'b0);
        checkOutput("t4_next");

        $display("[TB] reset mid-run");
        start = 1'b1; bias = 16'h0000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1; prod = 16'h2000;
            tick();
        end
        prod_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_sum", {16'd0, sum}, 32'd0);
        rst = 1'b0;
        applyStimulus(16'h0000, t1, 0, 16'h3000, 1'b0, 1'b0);
        checkOutput("t5_fresh");

        $display("[TB] negative result");
`ifdef FXP_NEURON_RELU_EN
        applyStimulus(16'hA000, {16'h0000, 16'h2000, 16'hA000, 16'hA000}, 0, 16'h0000, 1'b0, 1'b0);
`else
        applyStimulus(16'hA000, {16'h0000, 16'h2000, 16'hA000, 16'hA000}, 0, 16'hC000, 1'b0, 1'b0);
`endif
        checkOutput("t6");

        $display("[TB] edge of range and random runs");
        pr = {16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
        e  = model(16'h0000, pr);
        applyStimulus(16'h0000, pr, 0, e.sum, e.ovf, 1'b0);
        checkOutput("max_exact");
        pr = {16'h0000, 16'h0000, 16'h8001, 16'hFFFF};
        e  = model(16'h0000, pr);
        applyStimulus(16'h0000, pr, 0, e.sum, e.ovf, 1'b0);
        checkOutput("min_over");
        for (int r = 0; r < 6; r++) begin
            logic [15:0] rb;
            rb = 16'($urandom);
            for (int i = 0; i < 4; i++) pr[i] = 16'($urandom >> (r % 3));
            e = model(rb, pr);
            applyStimulus(rb, pr, int'($urandom_range(0, 2)), e.sum, e.ovf, 1'b0);
            checkOutput("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
